// File: rtl/cpu_types_pkg.sv
// Shared core types: the 32-bit machine word and the fetch controller state encoding.
`default_nettype none

package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
// Bundle between the decode/EX redirect sources, the icache and the fetch controller.
`default_nettype none

interface fetch_ctrl_if;
   import cpu_types_pkg::*;

   logic  ihit;
   logic  dstall;
   logic  br_taken;
   word_t br_target;
   logic  jmp_req;
   word_t jmp_target;
   logic  halt;
   logic  pc_en;
   logic  pc_control;
   word_t nxt_pc;
   logic  imemREN;
   logic  flush_ifid;
   logic  flush_idex;
   logic  halted;

   modport fetch_ctrl (
      input  ihit, dstall, br_taken, br_target, jmp_req, jmp_target, halt,
      output pc_en, pc_control, nxt_pc, imemREN, flush_ifid, flush_idex, halted
   );

endinterface

`default_nettype wire

// File: rtl/redirect_buf.sv
// Redirect priority (branch > jump > pending) and the one-entry buffer that holds a
// redirect until fetch can advance.
`default_nettype none

module redirect_buf
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
) (
   input  logic  CLK,
   input  logic  RST,
   input  logic  active_i,
   input  logic  adv_i,
   input  logic  br_taken_i,
   input  word_t br_target_i,
   input  logic  jmp_req_i,
   input  word_t jmp_target_i,
   output logic  redir_o,
   output word_t sel_o
);

   logic  pend_v_q,   pend_v_d;
   word_t pend_tgt_q, pend_tgt_d;
   logic  pend_br_q,  pend_br_d;

   logic  w_br;
   logic  w_jmp;

   // Requests arriving while halted are on a dead path and must not touch the buffer.
   assign w_br  = active_i & br_taken_i;
   assign w_jmp = active_i & jmp_req_i;

   assign redir_o = w_br | w_jmp | pend_v_q;
   assign sel_o   = w_br  ? br_target_i  :
                    w_jmp ? jmp_target_i : pend_tgt_q;

   always_comb begin
      pend_v_d   = pend_v_q;
      pend_tgt_d = pend_tgt_q;
      pend_br_d  = pend_br_q;
      if (active_i) begin
         if (redir_o && !adv_i) begin
            // A jump never displaces an older pending branch.
            if (w_br || !pend_v_q) begin
               pend_v_d   = 1'b1;
               pend_tgt_d = sel_o;
               pend_br_d  = w_br;
            end
         end else if (adv_i && redir_o) begin
            pend_v_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pend_v_q   <= 1'b0;
         pend_tgt_q <= PC_INIT;
         pend_br_q  <= 1'b0;
      end else begin
         pend_v_q   <= pend_v_d;
         pend_tgt_q <= pend_tgt_d;
         pend_br_q  <= pend_br_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// PC sequencing / fetch enable / flush / sticky halt for the pipelined MIPS core.
// Optional performance counters are built when FETCH_PERF_EN is defined.
`default_nettype none

module fetch_ctrl
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000
`ifdef FETCH_PERF_EN
   ,
   parameter int    CNT_W   = 32
`endif
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dstall,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             jmp_req,
   input  logic [31:0]      jmp_target,
   input  logic             halt,
   output logic             pc_en,
   output logic             pc_control,
   output logic [31:0]      nxt_pc,
   output logic             imemREN,
   output logic             flush_ifid,
   output logic             flush_idex,
`ifdef FETCH_PERF_EN
   output logic [CNT_W-1:0] perf_stall,
   output logic [CNT_W-1:0] perf_redir,
   output logic [CNT_W-1:0] perf_flush,
`endif
   output logic             halted
);

   fetch_state_t state_q, state_d;

   logic  w_active;
   logic  w_adv;
   logic  w_redir;
   word_t w_sel;

   assign w_active = (state_q != HALT);
   assign w_adv    = w_active & ihit & ~dstall;

   redirect_buf #(
      .PC_INIT (PC_INIT)
   ) u_redirect_buf (
      .CLK          (CLK),
      .RST          (RST),
      .active_i     (w_active),
      .adv_i        (w_adv),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .jmp_req_i    (jmp_req),
      .jmp_target_i (jmp_target),
      .redir_o      (w_redir),
      .sel_o        (w_sel)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN: begin
            if (halt && !br_taken) state_d = HALT;
            else if (!w_adv)       state_d = STALL;
         end
         STALL: begin
            if (halt && !br_taken) state_d = HALT;
            else if (w_adv)        state_d = RUN;
         end
         HALT:    state_d = HALT;
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Reset masks every output combinationally, independent of the registered state.
   assign pc_en      = ~RST & w_adv;
   assign pc_control = ~RST & w_adv & w_redir;
   assign nxt_pc     = (!RST && w_redir) ? w_sel : PC_INIT;
   assign imemREN    = ~RST & w_active;
   assign flush_ifid = ~RST & w_active & (br_taken | jmp_req);
   assign flush_idex = ~RST & w_active & br_taken;
   assign halted     = ~RST & (state_q == HALT);

`ifdef FETCH_PERF_EN
   localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] stall_q, redir_q, flush_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_q <= '0;
         redir_q <= '0;
         flush_q <= '0;
      end else if (w_active) begin
         if (!w_adv && !(&stall_q))             stall_q <= stall_q + c_one;
         if (w_adv && w_redir && !(&redir_q))   redir_q <= redir_q + c_one;
         if (br_taken && !(&flush_q))           flush_q <= flush_q + c_one;
      end
   end

   assign perf_stall = stall_q;
   assign perf_redir = redir_q;
   assign perf_flush = flush_q;
`endif

endmodule

`default_nettype wire
